// File: rtl/second_game_pkg.sv
// Shared types, colour constants and viewport defaults for the second-game
// renderer. Optional feature macro used by the top: SECOND_GAME_SPRITE_BLINK_EN.
package second_game_pkg;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t BLACK_COLOR    = 12'h000;
    localparam rgb12_t SPRITE0_COLOR  = 12'hF00;
    localparam rgb12_t SPRITE1_COLOR  = 12'h0FF;
    localparam rgb12_t OBST_COLOR     = 12'h0F0;
    localparam rgb12_t BACKGND_COLOR  = 12'h00F;

    localparam int DEF_START_X       = 400;
    localparam int DEF_START_Y       = 0;
    localparam int DEF_SCREEN_WIDTH  = 400;
    localparam int DEF_SCREEN_HEIGHT = 600;

    // Width of a local coordinate able to address n pixels.
    function automatic int coord_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/second_game_sprite_hit.sv
// One sprite's square box test on signed local coordinates. Differences are
// 13-bit signed so sprites near the viewport edges never wrap.
module second_game_sprite_hit
    import second_game_pkg::*;
#(
    parameter int XW   = 9,
    parameter int YW   = 10,
    parameter int HALF = 20
) (
    input  logic signed [11:0] i_lx,
    input  logic signed [11:0] i_ly,
    input  logic [XW-1:0]      i_sx,
    input  logic [YW-1:0]      i_sy,
    input  logic               i_enbl,
    output logic               o_hit
);

    localparam logic signed [12:0] HALF_S = 13'(HALF);

    logic signed [12:0] dx;
    logic signed [12:0] dy;

    // Signed distance from the sprite centre, then a symmetric range check.
    always_comb begin
        dx    = signed'({i_lx[11], i_lx}) - signed'(13'(i_sx));
        dy    = signed'({i_ly[11], i_ly}) - signed'(13'(i_sy));
        o_hit = i_enbl && (dx >= -HALF_S) && (dx <= HALF_S)
                       && (dy >= -HALF_S) && (dy <= HALF_S);
    end

endmodule

// File: rtl/second_game_sprite_renderer.sv
// Two-stage pixel renderer for the second-game viewport with NUM_SPRITES
// frame-latched sprites, registered obstacle lookup and per-sprite collision.
// Optional feature: define SECOND_GAME_SPRITE_BLINK_EN to blink colliding
// sprites with a half-period of 2^BLINK_LOG2 frames.
module second_game_sprite_renderer
    import second_game_pkg::*;
#(
    parameter int SECOND_GAME_START_X       = DEF_START_X,
    parameter int SECOND_GAME_START_Y       = DEF_START_Y,
    parameter int SECOND_GAME_SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SECOND_GAME_SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int NUM_SPRITES               = 2,
    parameter int SPRITE_HALF_SIZE          = 20,
    parameter logic [NUM_SPRITES*12-1:0] SPRITE_COLORS = {SPRITE1_COLOR, SPRITE0_COLOR},
    parameter rgb12_t OBSTACLE_COLOR        = OBST_COLOR,
    parameter rgb12_t BKG_COLOR             = BACKGND_COLOR,
    parameter int BLINK_LOG2                = 4,
    localparam int XW = coord_w(SECOND_GAME_SCREEN_WIDTH),
    localparam int YW = coord_w(SECOND_GAME_SCREEN_HEIGHT)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_frame_start,
    input  logic [NUM_SPRITES*XW-1:0] i_sprite_x,
    input  logic [NUM_SPRITES*YW-1:0] i_sprite_y,
    input  logic [NUM_SPRITES-1:0]    i_sprite_enbl,
    input  logic                      i_disp_enbl,
    input  logic [10:0]               i_h_coord,
    input  logic [9:0]                i_v_coord,
    output logic [XW-1:0]             o_screen_x,
    output logic [YW-1:0]             o_screen_y,
    input  logic                      i_is_obstacle,
    output logic [3:0]                o_red,
    output logic [3:0]                o_green,
    output logic [3:0]                o_blue,
    output logic [NUM_SPRITES-1:0]    o_collision,
    output logic                      o_collision_any
);

    localparam logic signed [11:0] START_X_S = 12'(SECOND_GAME_START_X);
    localparam logic signed [11:0] START_Y_S = 12'(SECOND_GAME_START_Y);
    localparam logic signed [11:0] WIDTH_S   = 12'(SECOND_GAME_SCREEN_WIDTH);
    localparam logic signed [11:0] HEIGHT_S  = 12'(SECOND_GAME_SCREEN_HEIGHT);

    // Stage 0: global to local coordinate mapping.
    logic signed [11:0] lx, ly;
    logic               in_win;

    // Registered state.
    logic signed [11:0]        lx_q, lx_d, ly_q, ly_d;
    logic                      in_win_q, in_win_d, disp_q, disp_d;
    logic                      armed_q, armed_d;
    logic [NUM_SPRITES*XW-1:0] sx_q, sx_d;
    logic [NUM_SPRITES*YW-1:0] sy_q, sy_d;
    logic [NUM_SPRITES-1:0]    se_q, se_d;
    logic [NUM_SPRITES-1:0]    sticky_q, sticky_d;
    logic [NUM_SPRITES-1:0]    col_q, col_d;
    logic                      any_q, any_d;
    rgb12_t                    rgb_q, rgb_d;

    logic [NUM_SPRITES-1:0]    hit, hide, draw, new_col;
    logic                      pix_active;

    // Map the raster position into the viewport and flag whether it lies inside.
    always_comb begin
        lx     = signed'({1'b0, i_h_coord}) - START_X_S;
        ly     = signed'({2'b00, i_v_coord}) - START_Y_S;
        in_win = (lx >= 12'sd0) && (lx < WIDTH_S) && (ly >= 12'sd0) && (ly < HEIGHT_S);
    end

    assign o_screen_x = lx[XW-1:0];
    assign o_screen_y = ly[YW-1:0];

    // Stage 1 box tests, one instance per sprite against the frame shadow copy.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
            second_game_sprite_hit #(
                .XW  (XW),
                .YW  (YW),
                .HALF(SPRITE_HALF_SIZE)
            ) u_hit (
                .i_lx  (lx_q),
                .i_ly  (ly_q),
                .i_sx  (sx_q[gi*XW +: XW]),
                .i_sy  (sy_q[gi*YW +: YW]),
                .i_enbl(se_q[gi]),
                .o_hit (hit[gi])
            );
        end
    endgenerate

`ifdef SECOND_GAME_SPRITE_BLINK_EN
    logic [BLINK_LOG2:0] blink_q, blink_d;

    // Frame counter whose top bit gates the drawing of colliding sprites.
    always_comb begin
        blink_d = blink_q + (BLINK_LOG2+1)'(i_frame_start);
        hide    = col_q & {NUM_SPRITES{blink_q[BLINK_LOG2]}};
    end

    // Blink counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) blink_q <= '0;
        else       blink_q <= blink_d;
    end
`else
    assign hide = '0;
`endif

    // Next-state logic: shadow latching, colour selection and collision capture.
    always_comb begin
        lx_d     = lx;
        ly_d     = ly;
        in_win_d = in_win;
        disp_d   = i_disp_enbl;
        armed_d  = armed_q | i_frame_start;
        sx_d     = i_frame_start ? i_sprite_x    : sx_q;
        sy_d     = i_frame_start ? i_sprite_y    : sy_q;
        se_d     = i_frame_start ? i_sprite_enbl : se_q;

        // Black until the first frame after reset, outside the window or when blanked.
        pix_active = armed_q && disp_q && in_win_q;
        draw       = hit & ~hide;
        rgb_d      = BLACK_COLOR;
        if (pix_active) begin
            rgb_d = i_is_obstacle ? OBSTACLE_COLOR : BKG_COLOR;
            for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
                if (draw[k]) rgb_d = SPRITE_COLORS[k*12 +: 12];
            end
        end

        // Hits arriving with the frame pulse belong to the new frame.
        new_col  = hit & {NUM_SPRITES{disp_q && in_win_q && i_is_obstacle}};
        sticky_d = (i_frame_start ? '0 : sticky_q) | new_col;
        col_d    = i_frame_start ? sticky_q  : col_q;
        any_d    = i_frame_start ? |sticky_q : any_q;
    end

    // All pipeline and frame state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lx_q     <= '0;
            ly_q     <= '0;
            in_win_q <= 1'b0;
            disp_q   <= 1'b0;
            armed_q  <= 1'b0;
            sx_q     <= '0;
            sy_q     <= '0;
            se_q     <= '0;
            sticky_q <= '0;
            col_q    <= '0;
            any_q    <= 1'b0;
            rgb_q    <= BLACK_COLOR;
        end else begin
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            in_win_q <= in_win_d;
            disp_q   <= disp_d;
            armed_q  <= armed_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            se_q     <= se_d;
            sticky_q <= sticky_d;
            col_q    <= col_d;
            any_q    <= any_d;
            rgb_q    <= rgb_d;
        end
    end

    assign o_red           = rgb_q[11:8];
    assign o_green         = rgb_q[7:4];
    assign o_blue          = rgb_q[3:0];
    assign o_collision     = col_q;
    assign o_collision_any = any_q;

endmodule

// File: tb/tb_second_game_sprite_renderer.sv
// Directed bench for second_game_sprite_renderer (default build, 2 sprites).
module tb_second_game_sprite_renderer;

    localparam int XW = 9;
    localparam int YW = 10;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_frame_start;
    logic [2*XW-1:0] i_sprite_x;
    logic [2*YW-1:0] i_sprite_y;
    logic [1:0]    i_sprite_enbl;
    logic          i_disp_enbl;
    logic [10:0]   i_h_coord;
    logic [9:0]    i_v_coord;
    logic [XW-1:0] o_screen_x;
    logic [YW-1:0] o_screen_y;
    logic          i_is_obstacle;
    logic [3:0]    o_red, o_green, o_blue;
    logic [1:0]    o_collision;
    logic          o_collision_any;

    int checks = 0;
    int errors = 0;

    // Single-entry obstacle map with one cycle of read latency.
    logic          obs_en;
    logic [XW-1:0] obs_x;
    logic [YW-1:0] obs_y;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk)
        i_is_obstacle <= obs_en && (o_screen_x == obs_x) && (o_screen_y == obs_y);

    second_game_sprite_renderer dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_frame_start  (i_frame_start),
        .i_sprite_x     (i_sprite_x),
        .i_sprite_y     (i_sprite_y),
        .i_sprite_enbl  (i_sprite_enbl),
        .i_disp_enbl    (i_disp_enbl),
        .i_h_coord      (i_h_coord),
        .i_v_coord      (i_v_coord),
        .o_screen_x     (o_screen_x),
        .o_screen_y     (o_screen_y),
        .i_is_obstacle  (i_is_obstacle),
        .o_red          (o_red),
        .o_green        (o_green),
        .o_blue         (o_blue),
        .o_collision    (o_collision),
        .o_collision_any(o_collision_any)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        if (obs === exp) $display("check %-22s observed %h expected %h ok", tag, obs, exp);
    endtask

    // Present one pixel, replace it with a blank pixel after one edge, and
    // check the colour exactly two edges after it was presented.
    task automatic pixel(input string tag, input int h, input int v, input logic de,
                         input logic [11:0] exp);
        i_h_coord   = 11'(h);
        i_v_coord   = 10'(v);
        i_disp_enbl = de;
        @(posedge i_clk); #1;
        i_h_coord   = '0;
        i_v_coord   = '0;
        i_disp_enbl = 1'b0;
        @(posedge i_clk); #1;
        chk(tag, {o_red, o_green, o_blue}, exp);
    endtask

    task automatic frame();
        i_frame_start = 1'b1;
        @(posedge i_clk); #1;
        i_frame_start = 1'b0;
    endtask

    task automatic set_sprites(input int x0, input int y0, input logic e0,
                               input int x1, input int y1, input logic e1);
        i_sprite_x    = {9'(x1), 9'(x0)};
        i_sprite_y    = {10'(y1), 10'(y0)};
        i_sprite_enbl = {e1, e0};
    endtask

    initial begin
        i_rst = 1'b1; i_frame_start = 1'b0; i_disp_enbl = 1'b0;
        i_h_coord = '0; i_v_coord = '0;
        obs_en = 1'b0; obs_x = '0; obs_y = '0;
        set_sprites(0, 0, 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_rgb", {o_red, o_green, o_blue}, 12'h000);
        chk("reset_collision", 12'(o_collision), 12'h000);
        chk("reset_any", 12'(o_collision_any), 12'h000);
        i_rst = 1'b0;

        // Black before the first frame pulse after reset.
        pixel("pre_frame_black", 500, 100, 1'b1, 12'h000);

        // Basic sprite and window tests.
        set_sprites(100, 100, 1'b1, 0, 0, 1'b0);
        frame();
        pixel("sprite0_centre", 500, 100, 1'b1, 12'hF00);
        pixel("sprite0_edge", 520, 100, 1'b1, 12'hF00);
        pixel("sprite0_past_edge", 521, 100, 1'b1, 12'h00F);
        pixel("outside_viewport", 300, 100, 1'b1, 12'h000);
        pixel("disp_disabled", 500, 100, 1'b0, 12'h000);

        // Sprite near the left edge: covers lx 0..25 only.
        set_sprites(5, 100, 1'b1, 0, 0, 1'b0);
        frame();
        pixel("left_edge_lx0", 400, 100, 1'b1, 12'hF00);
        pixel("left_edge_lx26", 426, 100, 1'b1, 12'h00F);
        pixel("right_side_far", 799, 100, 1'b1, 12'h00F);

        // Overlapping sprites: lowest index wins.
        set_sprites(200, 300, 1'b1, 200, 300, 1'b1);
        frame();
        pixel("overlap_priority", 600, 300, 1'b1, 12'hF00);
        set_sprites(200, 300, 1'b0, 200, 300, 1'b1);
        frame();
        pixel("sprite1_alone", 600, 300, 1'b1, 12'h0FF);

        // Obstacle colour where no sprite is present.
        obs_en = 1'b1; obs_x = 9'd110; obs_y = 10'd100;
        set_sprites(300, 300, 1'b1, 0, 0, 1'b0);
        frame();
        pixel("obstacle_color", 510, 100, 1'b1, 12'h0F0);

        // Collision against the obstacle at local (110,100).
        set_sprites(100, 100, 1'b1, 0, 0, 1'b0);
        frame();
        chk("no_collision_yet", 12'(o_collision), 12'h000);
        pixel("sprite_over_obstacle", 510, 100, 1'b1, 12'hF00);
        chk("collision_held_prev", 12'(o_collision), 12'h000);
        frame();
        chk("collision_reported", 12'(o_collision), 12'h001);
        chk("collision_any_set", 12'(o_collision_any), 12'h001);
`ifndef SECOND_GAME_SPRITE_BLINK_EN
        pixel("colliding_visible", 500, 100, 1'b1, 12'hF00);
`endif
        obs_en = 1'b0;
        pixel("clean_frame_pixel", 510, 100, 1'b1, 12'hF00);
        frame();
        chk("collision_cleared", 12'(o_collision), 12'h000);
        chk("collision_any_clear", 12'(o_collision_any), 12'h000);

        // Mid-frame position change takes effect on the next frame.
        set_sprites(100, 100, 1'b1, 0, 0, 1'b0);
        frame();
        set_sprites(200, 100, 1'b1, 0, 0, 1'b0);
        pixel("midframe_old_pos", 500, 100, 1'b1, 12'hF00);
        pixel("midframe_new_not_yet", 600, 100, 1'b1, 12'h00F);
        frame();
        pixel("nextframe_new_pos", 600, 100, 1'b1, 12'hF00);
        pixel("nextframe_old_gone", 500, 100, 1'b1, 12'h00F);

        // Reset mid-frame blanks output until the next frame pulse.
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        pixel("midframe_reset_black", 600, 100, 1'b1, 12'h000);

        // Reset wins over a simultaneous frame pulse.
        i_rst = 1'b1; i_frame_start = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_frame_start = 1'b0;
        pixel("rst_beats_frame", 600, 100, 1'b1, 12'h000);
        frame();
        pixel("recovered_after_rst", 600, 100, 1'b1, 12'hF00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
